md_ctrl: RTL and testbench

//  Multiply/divide unit controller for the 5-stage MIPS pipeline. Takes a mult/div/mthi/mtlo
//  op issued from the E stage, runs it for a fixed latency, and owns the HI/LO registers.

---
 rtl/md_ctrl.sv | 156 +++++++++++++++
 tb/tb_md_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : md_ctrl
//  Purpose  : Multiply/divide controller for the 5-stage MIPS pipeline. Accepts
//             mult/multu/div/divu/mthi/mtlo from the E stage, runs the
//             arithmetic ops for a fixed latency, owns HI/LO and asks the
//             F/D stages to stall while a HI/LO user has to wait.
//  Ports    : clk       - clock, rising edge
//             reset     - synchronous active-high reset
//             start     - E-stage instruction is an MD op
//             md_op     - 001 mult, 010 multu, 011 div, 100 divu,
//                         101 mthi, 110 mtlo, others no-op
//             rs_val    - forwarded rs operand
//             rt_val    - forwarded rt operand
//             md_use_D  - D-stage instruction touches the MD unit
//             hi / lo   - HI / LO registers
//             busy      - an arithmetic op is running
//             stall_md  - stall request for F/D
//  Revision : 1.0 - initial release
// ============================================================================
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam int c_MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(c_MAX_N + 1);

    localparam logic [CNT_W-1:0] c_MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_is_signed;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [31:0]      w_abs_a;
    logic [31:0]      w_abs_b;
    logic             w_b_zero;
    logic [31:0]      w_divisor;
    logic [31:0]      w_q_mag;
    logic [31:0]      w_r_mag;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic [63:0]      w_prod;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_write;
    logic             w_long_op;

    // Signed ops are handled on magnitudes so the 0x80000000 / -1 corner
    // needs no special case: its magnitude quotient 0x80000000 comes back
    // unchanged because both signs are negative.
    assign w_a_neg   = r_is_signed & r_a[31];
    assign w_b_neg   = r_is_signed & r_b[31];
    assign w_abs_a   = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_abs_b   = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_b_zero  = (r_b == 32'd0);
    assign w_divisor = w_b_zero ? 32'd1 : w_abs_b;
    assign w_q_mag   = w_abs_a / w_divisor;
    assign w_r_mag   = w_abs_a % w_divisor;
    assign w_quot    = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Sign- or zero-extending to 64 bits makes one 64-bit multiply serve
    // both mult and multu (low 64 bits of a two's-complement product).
    assign w_prod    = {{32{w_a_neg}}, r_a} * {{32{w_b_neg}}, r_b};

    assign w_res_hi  = r_is_div ? w_rem  : w_prod[63:32];
    assign w_res_lo  = r_is_div ? w_quot : w_prod[31:0];

    // Divide by zero still burns the full latency but leaves HI/LO alone.
    assign w_write   = ~(r_is_div & w_b_zero);

    assign w_long_op = (md_op == c_OP_MULT) || (md_op == c_OP_MULTU) ||
                       (md_op == c_OP_DIV)  || (md_op == c_OP_DIVU);

    assign stall_md  = md_use_D & (r_busy | (start & w_long_op));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_is_signed <= 1'b0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else if (r_busy) begin
            // New starts are ignored while busy; only the countdown runs.
            r_cnt <= r_cnt - c_ONE;
            if (r_cnt == c_ONE) begin
                r_busy <= 1'b0;
                if (w_write) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end
        end else if (start) begin
            case (md_op)
                c_OP_MULT, c_OP_MULTU: begin
                    r_busy      <= 1'b1;
                    r_cnt       <= c_MULT_N;
                    r_is_div    <= 1'b0;
                    r_is_signed <= (md_op == c_OP_MULT);
                    r_a         <= rs_val;
                    r_b         <= rt_val;
                end
                c_OP_DIV, c_OP_DIVU: begin
                    r_busy      <= 1'b1;
                    r_cnt       <= c_DIV_N;
                    r_is_div    <= 1'b1;
                    r_is_signed <= (md_op == c_OP_DIV);
                    r_a         <= rs_val;
                    r_b         <= rt_val;
                end
                c_OP_MTHI: r_hi <= rs_val;
                c_OP_MTLO: r_lo <= rs_val;
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_ctrl
//  Purpose  : Directed self-checking bench for md_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    int checks = 0;
    int errors = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_use_D (md_use_D),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive an op for one edge, then scramble operands to prove capture.
    // Returns 1 ns after the accept edge, i.e. inside cycle T+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        md_op  = 3'b000;
        rs_val = 32'hDEAD_BEEF;
        rt_val = 32'h0BAD_F00D;
    endtask

    // Count busy cycles starting from cycle T+1; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; md_op = 3'b000;
        rs_val = 32'd0; rt_val = 32'd0; md_use_D = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
        end
        checks++;
        if (busy !== 1'b0 || stall_md !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got busy=%b stall=%b expected 0/0", busy, stall_md);
        end
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int n;
        issue(3'b001, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL mult_latency: got %0d expected 5", n); end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL mult_result: got %h_%h expected ffffffff_fffffffe", hi, lo);
        end
        issue(3'b010, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL multu_latency: got %0d expected 5", n); end
        checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL multu_result: got %h_%h expected 00000001_fffffffe", hi, lo);
        end
    endtask

    task automatic test_div;
        int n;
        issue(3'b011, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL div_latency: got %0d expected 10", n); end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_result: got hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
        end
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL divu_latency: got %0d expected 10", n); end
        checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'h7FFF_FFFC) begin
            errors++; $display("FAIL divu_result: got hi=%h lo=%h expected 00000001/7ffffffc", hi, lo);
        end
        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            errors++; $display("FAIL div_overflow: got hi=%h lo=%h expected 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo;
        // lo is 0x80000000 from the previous test.
        @(negedge clk);
        start = 1'b1; md_op = 3'b101; rs_val = 32'h0000_1234;
        @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h8000_0000 || busy !== 1'b0) begin
            errors++; $display("FAIL mthi: got hi=%h lo=%h busy=%b expected 00001234/80000000/0", hi, lo, busy);
        end
        md_op = 3'b110; rs_val = 32'h0000_5678;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = 3'b000;
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678 || busy !== 1'b0) begin
            errors++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b expected 00001234/00005678/0", hi, lo, busy);
        end
        // Reserved opcode 111 must do nothing.
        issue(3'b111, 32'hAAAA_AAAA, 32'd3);
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678 || busy !== 1'b0) begin
            errors++; $display("FAIL op_111: got hi=%h lo=%h busy=%b expected 00001234/00005678/0", hi, lo, busy);
        end
    endtask

    task automatic test_div_zero;
        int n;
        issue(3'b101, 32'h0000_000A, 32'd0);
        issue(3'b110, 32'h0000_000B, 32'd0);
        issue(3'b011, 32'h0000_0064, 32'd0);
        count_busy(n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL divzero_latency: got %0d expected 10", n); end
        checks++;
        if (hi !== 32'h0000_000A || lo !== 32'h0000_000B) begin
            errors++; $display("FAIL divzero_result: got hi=%h lo=%h expected 0000000a/0000000b", hi, lo);
        end
    endtask

    task automatic test_stall_and_ignore;
        int n;
        int stall_bad;
        // Combinational stall from E-stage start with no busy.
        @(negedge clk);
        md_use_D = 1'b1; start = 1'b1; md_op = 3'b001;
        #1;
        checks++;
        if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_start: got %b expected 1", stall_md); end
        md_op = 3'b101;
        #1;
        checks++;
        if (stall_md !== 1'b0) begin errors++; $display("FAIL stall_mthi: got %b expected 0", stall_md); end
        start = 1'b0; md_op = 3'b000;
        // mult 3*4 with a divu attempted while busy; divu must be ignored.
        issue(3'b001, 32'd3, 32'd4);
        stall_bad = 0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (stall_md !== 1'b1) stall_bad++;
            if (n == 1) begin start = 1'b1; md_op = 3'b100; rs_val = 32'd99; rt_val = 32'd7; end
            if (n == 2) begin start = 1'b0; md_op = 3'b000; end
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL stall_busy: got %0d non-stall cycles expected 0", stall_bad); end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL ignore_latency: got %0d expected 5", n); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd12 || stall_md !== 1'b0) begin
            errors++; $display("FAIL ignore_result: got hi=%h lo=%h stall=%b expected 0/0000000c/0", hi, lo, stall_md);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_reload: got busy=%b expected 0", busy); end
        md_use_D = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        int late;
        issue(3'b001, 32'hFFFF_FFFF, 32'd2);   // now in busy cycle 1
        @(posedge clk); #1;                     // busy cycle 2
        @(posedge clk); #1;                     // busy cycle 3
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        late = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late++;
        end
        checks++;
        if (late !== 0) begin errors++; $display("FAIL reset_no_late_write: got %0d bad cycles expected 0", late); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_mthi_mtlo;
        test_div_zero;
        test_stall_and_ignore;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
